// File: rtl/ps2_key_controller.sv
// ps2_key_controller: PS/2 scancode-set-2 sequencer for the dinosaur game.
// Tracks E0 (extended) / F0 (break) prefixes and per-key held flags, and emits
// jump/start pulses, the duck level and a protocol-error pulse. All outputs are
// registered and reflect a byte exactly one cycle after its strobe.
// Optional build macro: KEY_REPEAT_EN adds periodic jump pulses while a jump key
// stays held.
module ps2_key_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES  = 6250000,
  parameter logic [7:0]  SPACE_CODE     = 8'h29,
  parameter logic [7:0]  UP_CODE        = 8'h75,
  parameter logic [7:0]  DOWN_CODE      = 8'h72,
  parameter logic [7:0]  ENTER_CODE     = 8'h5A
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       jump_pulse,
  output logic       duck,
  output logic       start_pulse,
  output logic [3:0] held_keys,
  output logic       proto_err
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("ps2_key_controller: TIMEOUT_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

  state_e          state_q, state_d;
  logic [3:0]      held_q, held_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            jump_q, jump_d;
  logic            start_q, start_d;
  logic            err_q, err_d;
  logic            duck_q, duck_d;
  logic            jh_q, jh_d;
  logic            rpt_fire;
  logic            is_err_byte;

  assign is_err_byte = (byte_in == 8'h00) || (byte_in == 8'hFF) ||
                       (byte_in == 8'hFC) || (byte_in == 8'hFE);

  // Prefix FSM, held-flag update and inactivity timeout.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    to_d    = to_q;
    err_d   = 1'b0;
    if (byte_valid) begin
      to_d = '0;
      if (is_err_byte) begin
        held_d  = '0;
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            // ACK/BAT bytes and unknown codes fall through with no effect.
            if (byte_in == 8'hE0)            state_d = EXT;
            else if (byte_in == 8'hF0)       state_d = BRK;
            else if (byte_in == SPACE_CODE)  held_d[0] = 1'b1;
            else if (byte_in == ENTER_CODE)  held_d[3] = 1'b1;
          end
          EXT: begin
            state_d = IDLE;
            if (byte_in == 8'hF0)            state_d = EXT_BRK;
            else if (byte_in == 8'hE0)       err_d = 1'b1;
            else if (byte_in == UP_CODE)     held_d[1] = 1'b1;
            else if (byte_in == DOWN_CODE)   held_d[2] = 1'b1;
          end
          BRK: begin
            state_d = IDLE;
            if (byte_in == 8'hE0 || byte_in == 8'hF0) err_d = 1'b1;
            else if (byte_in == SPACE_CODE)  held_d[0] = 1'b0;
            else if (byte_in == ENTER_CODE)  held_d[3] = 1'b0;
          end
          EXT_BRK: begin
            state_d = IDLE;
            if (byte_in == 8'hE0 || byte_in == 8'hF0) err_d = 1'b1;
            else if (byte_in == UP_CODE)     held_d[1] = 1'b0;
            else if (byte_in == DOWN_CODE)   held_d[2] = 1'b0;
          end
          default: state_d = IDLE;
        endcase
      end
    end else begin
      if (to_q != TO_MAX) to_d = to_q + TO_W'(1);
      // A byte in the same cycle takes the other branch, so it always wins.
      if (to_q == TO_MAX && state_q != IDLE) state_d = IDLE;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned RP_W = $clog2(REPEAT_CYCLES);
  localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_CYCLES - 1);

  logic [RP_W-1:0] rpt_q, rpt_d;

  // Repeat counter: runs while a jump key stays held; fires as it reaches its top.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (jh_q && jh_d) begin
      rpt_d    = (rpt_q == RP_MAX) ? '0 : rpt_q + RP_W'(1);
      rpt_fire = (rpt_d == RP_MAX);
    end
  end

  // Repeat counter register.
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Edge-detected game controls derived from the old and new held flags.
  always_comb begin
    jh_q    = held_q[0] | held_q[1];
    jh_d    = held_d[0] | held_d[1];
    jump_d  = (jh_d & ~jh_q) | rpt_fire;
    start_d = held_d[3] & ~held_q[3];
    duck_d  = held_d[2];
  end

  // State and output registers.
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      held_q  <= '0;
      to_q    <= '0;
      jump_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      duck_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      to_q    <= to_d;
      jump_q  <= jump_d;
      start_q <= start_d;
      err_q   <= err_d;
      duck_q  <= duck_d;
    end
  end

  assign jump_pulse  = jump_q;
  assign start_pulse = start_q;
  assign proto_err   = err_q;
  assign duck        = duck_q;
  assign held_keys   = held_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Self-checking bench for ps2_key_controller: directed scenarios plus a random
// byte stream compared against a behavioural model of the scancode rules.
module tb_ps2_key_controller;

  localparam int unsigned T = 16;
  localparam int unsigned R = 8;
  localparam logic [7:0] POOL [16] = '{8'h29, 8'h5A, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'hE0, 8'hF0,
                                       8'h29, 8'h72, 8'hFA, 8'hAA, 8'h11, 8'h1C, 8'h75, 8'h5A};
  localparam logic [7:0] ERRS [4] = '{8'h00, 8'hFF, 8'hFC, 8'hFE};

  logic       VGA_clk = 1'b0;
  logic       reset = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       jump_pulse, duck, start_pulse, proto_err;
  logic [3:0] held_keys;

  int checks = 0;
  int errors = 0;

  // Model state: pending prefixes, held flags, idle cycles, cycles since press.
  bit          m_ext, m_brk;
  logic [3:0]  m_held;
  int unsigned m_idle, m_age;
  logic        e_jump, e_start, e_err;

  ps2_key_controller #(
    .TIMEOUT_CYCLES(T),
    .REPEAT_CYCLES (R)
  ) dut (
    .VGA_clk    (VGA_clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .jump_pulse (jump_pulse),
    .duck       (duck),
    .start_pulse(start_pulse),
    .held_keys  (held_keys),
    .proto_err  (proto_err)
  );

  always #5 VGA_clk = ~VGA_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int key_idx(bit ext, logic [7:0] b);
    if (ext) return (b == 8'h75) ? 1 : (b == 8'h72) ? 2 : -1;
    return (b == 8'h29) ? 0 : (b == 8'h5A) ? 3 : -1;
  endfunction

  task automatic model_reset;
    m_ext = 0; m_brk = 0; m_held = '0; m_idle = 0; m_age = 0;
    e_jump = 0; e_start = 0; e_err = 0;
  endtask

  // Drive one clock cycle (byte or idle) and advance the model to match.
  task automatic step(input bit v, input logic [7:0] b);
    bit jh_old, jh_new, en_old;
    int k;
    byte_valid = v; byte_in = b;
    @(posedge VGA_clk); #1;
    byte_valid = 1'b0; byte_in = 8'h00;
    jh_old = m_held[0] | m_held[1];
    en_old = m_held[3];
    e_err  = 1'b0;
    if (v) begin
      m_idle = 0;
      if (b == 8'h00 || b == 8'hFF || b == 8'hFC || b == 8'hFE) begin
        m_held = '0; m_ext = 0; m_brk = 0; e_err = 1'b1;
      end else if ((b == 8'hE0 && (m_ext || m_brk)) || (b == 8'hF0 && m_brk)) begin
        m_ext = 0; m_brk = 0; e_err = 1'b1;
      end else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        k = key_idx(m_ext, b);
        if (k >= 0) m_held[k] = !m_brk;
        m_ext = 0; m_brk = 0;
      end
    end else begin
      m_idle++;
      if (m_idle >= T) begin m_ext = 0; m_brk = 0; end
    end
    jh_new = m_held[0] | m_held[1];
    if (jh_new && jh_old) m_age++; else m_age = 0;
    e_jump = jh_new && !jh_old;
`ifdef KEY_REPEAT_EN
    if (jh_new && jh_old && (m_age % R) == R - 1) e_jump = 1'b1;
`endif
    e_start = m_held[3] && !en_old;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge VGA_clk);
    #1;
    checks++;
    if ({jump_pulse, duck, start_pulse, proto_err, held_keys} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got %b expected 00000000",
               {jump_pulse, duck, start_pulse, proto_err, held_keys});
    end
    reset = 1'b0;
    model_reset();
    step(0, 8'h00);
    checks++;
    if ({jump_pulse, duck, start_pulse, proto_err, held_keys} !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: got %b expected 00000000",
               {jump_pulse, duck, start_pulse, proto_err, held_keys});
    end
  endtask

  task automatic test_typematic;
    logic [7:0] seq [6] = '{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29, 8'h00};
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(i < 5, seq[i]);
      if (jump_pulse === 1'b1) pulses++;
      checks++;
      if (jump_pulse !== (i == 0)) begin
        errors++;
        $display("FAIL typematic_jump[%0d]: got %b expected %b", i, jump_pulse, (i == 0));
      end
      checks++;
      if (held_keys[0] !== (i < 4)) begin
        errors++;
        $display("FAIL typematic_space[%0d]: got %b expected %b", i, held_keys[0], (i < 4));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL typematic_count: got %0d pulses expected 1", pulses);
    end
  endtask

  task automatic test_duck;
    step(1, 8'hE0); step(1, 8'h72);
    checks++;
    if (duck !== 1'b1 || held_keys !== 4'b0100) begin
      errors++;
      $display("FAIL duck_make: duck=%b held=%b expected 1 0100", duck, held_keys);
    end
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h72);
    checks++;
    if (duck !== 1'b0 || held_keys !== 4'b0000) begin
      errors++;
      $display("FAIL duck_break: duck=%b held=%b expected 0 0000", duck, held_keys);
    end
    step(1, 8'h72);
    checks++;
    if (duck !== 1'b0 || held_keys !== 4'b0000 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL duck_nonext: duck=%b held=%b err=%b expected 0 0000 0",
               duck, held_keys, proto_err);
    end
  endtask

  task automatic test_start;
    step(1, 8'h5A);
    checks++;
    if (start_pulse !== 1'b1 || held_keys !== 4'b1000) begin
      errors++;
      $display("FAIL start_pulse: start=%b held=%b expected 1 1000", start_pulse, held_keys);
    end
    step(0, 8'h00);
    checks++;
    if (start_pulse !== 1'b0) begin
      errors++;
      $display("FAIL start_width: start=%b expected 0", start_pulse);
    end
    step(1, 8'h29);
    checks++;
    if (jump_pulse !== 1'b1 || held_keys !== 4'b1001 || start_pulse !== 1'b0) begin
      errors++;
      $display("FAIL start_jump: jump=%b held=%b start=%b expected 1 1001 0",
               jump_pulse, held_keys, start_pulse);
    end
    step(1, 8'hF0); step(1, 8'h29); step(1, 8'hF0); step(1, 8'h5A);
    checks++;
    if (held_keys !== 4'b0000 || start_pulse !== 1'b0 || jump_pulse !== 1'b0) begin
      errors++;
      $display("FAIL start_release: held=%b start=%b jump=%b expected 0000 0 0",
               held_keys, start_pulse, jump_pulse);
    end
  endtask

  task automatic test_timeout;
    step(1, 8'hE0);
    repeat (T) step(0, 8'h00);
    step(1, 8'h72);
    checks++;
    if (duck !== 1'b0 || proto_err !== 1'b0 || held_keys !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_expired: duck=%b err=%b held=%b expected 0 0 0000",
               duck, proto_err, held_keys);
    end
    // Byte landing in the expiry cycle is still treated as extended.
    step(1, 8'hE0);
    repeat (T - 1) step(0, 8'h00);
    step(1, 8'h72);
    checks++;
    if (duck !== 1'b1 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_boundary: duck=%b err=%b expected 1 0", duck, proto_err);
    end
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h72);
    checks++;
    if (duck !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cleanup: duck=%b expected 0", duck);
    end
  endtask

  task automatic test_errors;
    step(1, 8'h29); step(1, 8'hFF);
    checks++;
    if (proto_err !== 1'b1 || held_keys !== 4'b0000) begin
      errors++;
      $display("FAIL err_byte: err=%b held=%b expected 1 0000", proto_err, held_keys);
    end
    step(0, 8'h00);
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL err_width: err=%b expected 0", proto_err);
    end
    step(1, 8'hF0); step(1, 8'hF0);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL err_f0f0: err=%b expected 1", proto_err);
    end
    step(1, 8'h29);
    checks++;
    if (jump_pulse !== 1'b1 || held_keys !== 4'b0001 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL err_idle_after: jump=%b held=%b err=%b expected 1 0001 0",
               jump_pulse, held_keys, proto_err);
    end
    step(1, 8'hE0); step(1, 8'hE0);
    checks++;
    if (proto_err !== 1'b1 || held_keys !== 4'b0001) begin
      errors++;
      $display("FAIL err_e0e0_keeps: err=%b held=%b expected 1 0001", proto_err, held_keys);
    end
    step(1, 8'hF0); step(1, 8'h29);
    checks++;
    if (held_keys !== 4'b0000) begin
      errors++;
      $display("FAIL err_cleanup: held=%b expected 0000", held_keys);
    end
  endtask

  task automatic test_random;
    int gap, r;
    logic [7:0] b;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(99);
      gap = (r < 70) ? 0 : (r < 92) ? $urandom_range(3, 1) : $urandom_range(T + 2, T - 2);
      if ($urandom_range(39) == 0) b = ERRS[$urandom_range(3)];
      else                         b = POOL[$urandom_range(15)];
      for (int g = 0; g <= gap; g++) begin
        step(g == gap, b);
        checks++;
        if ({jump_pulse, start_pulse, proto_err, duck, held_keys} !==
            {e_jump, e_start, e_err, m_held[2], m_held}) begin
          errors++;
          $display("FAIL random[%0d] byte=%h: got j/s/e/d/held=%b expected %b", n, b,
                   {jump_pulse, start_pulse, proto_err, duck, held_keys},
                   {e_jump, e_start, e_err, m_held[2], m_held});
        end
      end
    end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat;
    bit expv;
    for (int i = 1; i <= 30; i++) begin
      step(i == 1, 8'h29);
      expv = (i == 1 || i == 8 || i == 16 || i == 24);
      checks++;
      if (jump_pulse !== expv) begin
        errors++;
        $display("FAIL repeat_cycle[%0d]: jump=%b expected %b", i, jump_pulse, expv);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({jump_pulse, duck, start_pulse, proto_err, held_keys} !== 8'h00) begin
      errors++;
      $display("FAIL repeat_reset: got %b expected 00000000",
               {jump_pulse, duck, start_pulse, proto_err, held_keys});
    end
    @(posedge VGA_clk); #1;
    reset = 1'b0;
    model_reset();
  endtask
`endif

  task automatic test_reset_midhold;
    step(1, 8'hE0); step(1, 8'h72); step(1, 8'h29); step(0, 8'h00);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({jump_pulse, duck, start_pulse, proto_err, held_keys} !== 8'h00) begin
      errors++;
      $display("FAIL midhold_async: got %b expected 00000000",
               {jump_pulse, duck, start_pulse, proto_err, held_keys});
    end
    byte_valid = 1'b1; byte_in = 8'h29;
    repeat (2) @(posedge VGA_clk);
    #1;
    byte_valid = 1'b0; byte_in = 8'h00;
    reset = 1'b0;
    model_reset();
    step(0, 8'h00);
    checks++;
    if (held_keys !== 4'b0000 || jump_pulse !== 1'b0 || duck !== 1'b0) begin
      errors++;
      $display("FAIL midhold_ignored: held=%b jump=%b duck=%b expected 0000 0 0",
               held_keys, jump_pulse, duck);
    end
    step(1, 8'h29);
    checks++;
    if (held_keys !== 4'b0001 || jump_pulse !== 1'b1) begin
      errors++;
      $display("FAIL midhold_redetect: held=%b jump=%b expected 0001 1", held_keys, jump_pulse);
    end
    step(1, 8'hF0); step(1, 8'h29);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_typematic();
    test_duck();
    test_start();
    test_timeout();
    test_errors();
    test_random();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    test_reset_midhold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_controller.md
Name: ps2_key_controller

Overview:
- Scancode-set-2 sequencer between the PS/2 byte receiver and the dinosaur game logic.
- Consumes one-cycle byte strobes from the receiver and tracks prefix state (E0 extended, F0 break).
- Keeps per-key held flags and emits game-level controls: jump pulse, duck level, start pulse.
- Recovers from truncated sequences with an inactivity timeout and from keyboard error codes.

Parameters:
- TIMEOUT_CYCLES, 50000: VGA_clk cycles with no byte before a pending prefix is discarded (2 ms at 25 MHz).
- REPEAT_CYCLES, 6250000: auto-repeat jump interval, 250 ms; used only with KEY_REPEAT_EN.
- SPACE_CODE, 8'h29: jump key, non-extended.
- UP_CODE, 8'h75: jump key, E0-extended.
- DOWN_CODE, 8'h72: duck key, E0-extended.
- ENTER_CODE, 8'h5A: start key, non-extended.

Ports:
- VGA_clk, input, 1: system clock; the only clock.
- reset, input, 1: asynchronous, active-high reset.
- byte_valid, input, 1: one-cycle strobe; byte_in is valid in that cycle.
- byte_in, input, 8: received scancode byte.
- jump_pulse, output, 1: one-cycle jump request.
- duck, output, 1: high while the down arrow is held.
- start_pulse, output, 1: one-cycle start/restart request.
- held_keys, output, 4: held flags {enter, down, up, space}.
- proto_err, output, 1: one-cycle pulse on a protocol or keyboard error.

Behaviour:
- Reset (async assert, sync release): state=IDLE, held_keys=0, all outputs 0, timeout and repeat counters 0.
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
- IDLE transitions:
  - E0 -> EXT.
  - F0 -> BRK.
  - Any other byte is a make code; stay in IDLE.
- EXT transitions:
  - F0 -> EXT_BRK.
  - Any other byte is an extended make; go to IDLE.
- BRK: any byte is a break; go to IDLE.
- EXT_BRK: any byte is an extended break; go to IDLE.
- Make sets the matching held flag. Break clears it. Unknown codes are ignored.
- Extended codes update only up/down. Non-extended codes update only space/enter.
- FA (ACK) and AA (BAT pass) received in IDLE are ignored silently.
- Error bytes 00, FF, FC, FE received in any state:
  - held_keys cleared, state -> IDLE.
  - proto_err pulses.
- Illegal prefixes also go to IDLE with a proto_err pulse; the held flags are left untouched:
  - E0 received in EXT, BRK or EXT_BRK;
  - F0 received in BRK or EXT_BRK.
- jump_held = space | up.
- jump_pulse fires when jump_held goes 0->1. Typematic repeat make bytes for an already-held key produce no pulse.
- start_pulse fires on enter 0->1 only.
- duck = held_keys[2], registered.
- Latency: every output reflects a byte exactly 1 cycle after its byte_valid cycle. Pulses are exactly one cycle wide.
- Timeout counter:
  - cleared on every byte_valid;
  - otherwise increments and saturates at TIMEOUT_CYCLES-1;
  - reaching TIMEOUT_CYCLES-1 in a non-IDLE state forces IDLE with no proto_err and no held-flag change.
- If byte_valid and timeout expiry land in the same cycle, the byte wins: it is processed in the current state and the counter clears.
- byte_valid is ignored while reset is asserted.
- Reset asserted mid-sequence drops any partial prefix. A key still physically held after reset is re-detected only by its next make byte.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - A repeat counter runs while jump_held=1 and clears on each jump_held 0->1 edge.
  - When it reaches REPEAT_CYCLES-1, jump_pulse fires and the counter wraps to 0, giving periodic jumps while the key is held.
  - Releasing both jump keys stops the repeats and clears the counter.
- Undefined:
  - Exactly one jump_pulse per press.
  - No repeat counter is synthesised; REPEAT_CYCLES is unused.

Test Plan:
- Bytes 29, 29, 29 (typematic), then F0 29 -> exactly one jump_pulse, 1 cycle after the first 29; held_keys[0] goes 1 then back to 0 after the final 29.
- E0 72 -> duck=1 one cycle later. Then E0 F0 72 -> duck=0. Then a lone 72 (non-extended) -> duck stays 0.
- 5A -> start_pulse (single cycle). Then 29 while enter is held -> jump_pulse with held_keys=4'b1001.
- E0, then no byte for TIMEOUT_CYCLES (use a reduced parameter, e.g. 16, in sim), then 72 -> treated as non-extended, duck=0, proto_err=0.
- 29 held, then byte FF -> proto_err pulse, held_keys=0. Then F0 F0 -> proto_err pulse, state IDLE.
- KEY_REPEAT_EN with REPEAT_CYCLES=8: hold 29 for 30 cycles -> pulses at press+1, +8, +16, +24. Assert reset mid-hold -> all outputs 0 immediately.
